// File: rtl/clk_div_pkg.sv
// Shared constants and phase encoding for the parametrised clock divider.
`timescale 1ns/1ps
package clk_div_pkg;

  localparam int unsigned DEF_RATIO_W   = 8;
  localparam int unsigned MIN_DIV_RATIO = 2;

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_t;

endpackage

// File: rtl/clk_mux2.sv
// Glitch-safe 2:1 clock mux wrapper; kept as a dont-touch cell for synthesis and CTS.
`timescale 1ns/1ps
module clk_mux2 (
  input  logic clk0,
  input  logic clk1,
  input  logic sel,
  output logic clk_out
);

  assign clk_out = sel ? clk1 : clk0;

endmodule

// File: rtl/clk_div_param.sv
// Parametrised integer clock divider with period-boundary ratio updates and a period-start tick.
// Optional macro CLK_DIV_ODD_DUTY50_EN adds a negedge flop for exact 50% duty on odd ratios.
`timescale 1ns/1ps
module clk_div_param
  import clk_div_pkg::*;
#(
  parameter int unsigned RATIO_W = DEF_RATIO_W
) (
  input  logic               i_ref_clk,
  input  logic               i_rst_n,
  input  logic               i_clk_en,
  input  logic [RATIO_W-1:0] i_div_ratio,
  output logic               o_div_clk,
  output logic               o_div_tick,
  output logic               o_busy
);

  localparam int unsigned CNT_W = RATIO_W - 1;

  phase_t             phase_q, phase_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               tick_d;
  logic               busy_d;

  logic               start_ok;
  logic [RATIO_W-1:0] high_len;
  logic [RATIO_W-1:0] low_len;
  logic [CNT_W-1:0]   high_last;
  logic [CNT_W-1:0]   low_last;
  logic               div_clk;

  assign start_ok  = i_clk_en && (i_div_ratio >= RATIO_W'(MIN_DIV_RATIO));
  assign high_len  = ratio_q >> 1;
  assign low_len   = ratio_q - high_len;
  // Both phase lengths are at most 2^(RATIO_W-1), so their last index fits CNT_W bits.
  assign high_last = CNT_W'(high_len - RATIO_W'(1));
  assign low_last  = CNT_W'(low_len - RATIO_W'(1));

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_q    <= PH_LOW;
      ratio_q    <= '0;
      cnt_q      <= '0;
      div_q      <= 1'b0;
      o_div_tick <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      ratio_q    <= ratio_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      o_div_tick <= tick_d;
      o_busy     <= busy_d;
    end
  end

  // Next state: bypass tracks the requested ratio; dividing only reloads it at period boundaries.
  always_comb begin
    phase_d = phase_q;
    ratio_d = ratio_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    busy_d  = o_busy;

    if (!o_busy) begin
      ratio_d = i_div_ratio;
      if (start_ok) begin
        phase_d = PH_HIGH;
        div_d   = 1'b1;
        cnt_d   = '0;
        busy_d  = 1'b1;
        tick_d  = 1'b1;
      end
    end else if (phase_q == PH_HIGH) begin
      if (cnt_q == high_last) begin
        phase_d = PH_LOW;
        div_d   = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      if (cnt_q == low_last) begin
        ratio_d = i_div_ratio;
        cnt_d   = '0;
        if (start_ok) begin
          phase_d = PH_HIGH;
          div_d   = 1'b1;
          tick_d  = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic div_qn;

  // Half-cycle-delayed copy stretches the high phase by half a ref cycle on odd ratios.
  always_ff @(negedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_qn <= 1'b0;
    end else begin
      div_qn <= div_q;
    end
  end

  assign div_clk = ratio_q[0] ? (div_q | div_qn) : div_q;
`else
  assign div_clk = div_q;
`endif

  // Select flips only while ref and div_q are both high (entry) or both low-to-high (exit).
  clk_mux2 u_clk_mux (
    .clk0    (i_ref_clk),
    .clk1    (div_clk),
    .sel     (o_busy),
    .clk_out (o_div_clk)
  );

endmodule

// File: tb/tb_clk_div_param.sv
// Self-checking bench for clk_div_param: period-level model plus directed literal checks.
`timescale 1ns/1ps
module tb_clk_div_param;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [7:0] ratio = 8'd0;
  logic       div_clk;
  logic       tick;
  logic       busy;

  int checks = 0;
  int errors = 0;

`ifdef CLK_DIV_ODD_DUTY50_EN
  localparam bit ODD50 = 1'b1;
`else
  localparam bit ODD50 = 1'b0;
`endif

  clk_div_param #(.RATIO_W(8)) dut (
    .i_ref_clk   (clk),
    .i_rst_n     (rst_n),
    .i_clk_en    (en),
    .i_div_ratio (ratio),
    .o_div_clk   (div_clk),
    .o_div_tick  (tick),
    .o_busy      (busy)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position m_p within an m_n-cycle output period.
  bit m_busy = 1'b0;
  int m_n    = 0;
  int m_p    = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_n    = 0;
      m_p    = 0;
    end else if (!m_busy) begin
      if (en && ratio >= 8'd2) begin
        m_busy = 1'b1;
        m_n    = int'(ratio);
        m_p    = 0;
      end
    end else begin
      m_p++;
      if (m_p == m_n) begin
        m_p = 0;
        if (en && ratio >= 8'd2) m_n = int'(ratio);
        else m_busy = 1'b0;
      end
    end
  end

  // Output is high for the first hi half-cycles of the period.
  function automatic bit exp_clk(input bit high_half);
    int hp;
    int hi;
    if (!m_busy) return high_half;
    hp = 2 * m_p + (high_half ? 0 : 1);
    hi = ODD50 ? m_n : 2 * (m_n / 2);
    return hp < hi;
  endfunction

  task automatic cmp(input bit high_half);
    check("div_clk", int'(div_clk), int'(exp_clk(high_half)));
    check("busy", int'(busy), int'(m_busy));
    check("tick", int'(tick), int'(m_busy && m_p == 0));
  endtask

  initial begin
    forever begin
      @(posedge clk); #5; cmp(1'b1);
      @(negedge clk); #5; cmp(1'b0);
    end
  end

  // Edge timing of the divided clock.
  time rise_t   = 0;
  time period_t = 0;
  time high_t   = 0;
  time min_high = 1000;
  int  falls    = 0;

  always @(posedge div_clk) begin
    period_t = $time - rise_t;
    rise_t   = $time;
  end

  always @(negedge div_clk) begin
    high_t = $time - rise_t;
    if (high_t < min_high) min_high = high_t;
    falls++;
  end

  task automatic wait_falls(input int n);
    int f0;
    int k;
    f0 = falls;
    k  = 0;
    while ((falls - f0) < n && k < 400) begin
      @(posedge clk);
      k++;
    end
    check("fall_timeout", int'((falls - f0) >= n), 1);
  endtask

  initial begin
    int  c;
    bit  seen;
    time p_snap;
    time h_snap;

    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_tick", int'(tick), 0);
    rst_n = 1'b1;

    // Ratio 4: 80 ns period, 40 ns high, tick every 4th cycle.
    @(negedge clk);
    en    = 1'b1;
    ratio = 8'd4;
    @(posedge clk); #1;
    check("entry_tick", int'(tick), 1);
    check("entry_busy", int'(busy), 1);
    c = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (tick) c++;
    end
    check("tick_count4", c, 2);
    wait_falls(3);
    check("period4", int'(period_t), 80);
    check("high4", int'(high_t), 40);

    // Ratio 5: odd duty depends on the optional feature.
    @(negedge clk);
    ratio = 8'd5;
    wait_falls(3);
    check("period5", int'(period_t), 100);
    check("high5", int'(high_t), ODD50 ? 50 : 40);

    // Mid-period change 4 -> 6.
    @(negedge clk);
    ratio = 8'd4;
    wait_falls(3);
    min_high = 1000;
    repeat (2) @(negedge clk);
    ratio = 8'd6;
    wait_falls(3);
    check("period6", int'(period_t), 120);
    check("high6", int'(high_t), 60);
    check("no_runt", int'(min_high >= 40), 1);

    // Ratio 0 then 1: bypass.
    @(negedge clk);
    ratio = 8'd0;
    repeat (10) @(negedge clk);
    check("bypass0_busy", int'(busy), 0);
    ratio = 8'd1;
    repeat (5) @(negedge clk);
    check("bypass1_busy", int'(busy), 0);
    #5;
    check("bypass1_low", int'(div_clk), 0);

    // Ratio 8, drop enable mid-period: period completes then bypass.
    @(negedge clk);
    ratio = 8'd8;
    repeat (3) @(negedge clk);
    en = 1'b0;
    c      = 0;
    seen   = 1'b0;
    p_snap = 0;
    h_snap = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy) c++;
      else if (!seen) begin
        seen   = 1'b1;
        p_snap = period_t;
        h_snap = high_t;
      end
    end
    check("drop_busy_cycles", c, 5);
    check("drop_period", int'(p_snap), 160);
    check("drop_high", int'(h_snap), 80);

    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    check("resume_tick", int'(tick), 1);
    check("resume_busy", int'(busy), 1);

    // Reset during the high phase at ratio 6.
    @(negedge clk);
    ratio = 8'd6;
    wait_falls(2);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (tick) seen = 1'b1;
    end
    check("found_tick6", int'(seen), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_clk_hi", int'(div_clk), 1);
    @(negedge clk); #1;
    check("mid_rst_clk_lo", int'(div_clk), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_tick", int'(tick), 1);
    check("post_rst_busy", int'(busy), 1);
    wait_falls(3);
    check("post_rst_period", int'(period_t), 120);
    check("post_rst_high", int'(high_t), 60);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
